code_loader: RTL and testbench

CODE_LOADER -- requirements
Module: code_loader

---
 rtl/code_loader.sv | 162 ++++++++++++++++
 tb/tb_code_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/code_loader.sv
// code_loader: receives a code image over a byte stream and writes it into
// the CPU code memory, holding the CPU in reset until a frame with a valid
// checksum has been fully written.
//
// Frame: MAGIC, LEN_LO, LEN_HI, LEN x (low byte, high byte), CHK
// CHK is the XOR of every byte between MAGIC and CHK.
module code_loader #(
  parameter int          CODE_WIDTH = 13,
  parameter logic [7:0]  MAGIC      = 8'hB5,
  parameter int          TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  code_we,
  output logic [CODE_WIDTH-1:0] code_waddr,
  output logic [15:0]           code_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  error
);

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  // Largest accepted length is a full memory: 2^CODE_WIDTH words.
  localparam logic [31:0]     LEN_LIMIT  = 32'd1 << CODE_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, RUN, FAIL
  } state_t;

  state_t            state;
  logic [15:0]       len;
  logic [7:0]        low_byte;
  logic [7:0]        chk;
  // One bit wider than the memory address so a full-memory load can count
  // past the last word without wrapping to zero.
  logic [CODE_WIDTH:0] addr;
  logic [TW-1:0]     timer;

  logic [CODE_WIDTH:0] addr_inc;
  logic [15:0]         len_next;
  logic                last_word;
  logic                len_too_big;

  // Next-address, received length and end-of-data decisions.
  always_comb begin
    addr_inc    = addr + {{CODE_WIDTH{1'b0}}, 1'b1};
    len_next    = {rx_data, len[7:0]};
    last_word   = (32'(addr_inc) == {16'd0, len});
    len_too_big = ({16'd0, len_next} > LEN_LIMIT);
  end

  // Loader FSM with registered outputs, checksum, address and idle timer.
  // NOTE: every assignment here is non-blocking so all registers update from
  // the same pre-edge values; later assignments in this block override
  // earlier ones, which is how the timeout takes over a quiet cycle.
  // NOTE: the code memory itself lives outside this block and is never
  // cleared by reset; only the loader's control state is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      error      <= 1'b0;
      code_we    <= 1'b0;
      code_waddr <= '0;
      code_wdata <= '0;
      chk        <= '0;
      timer      <= '0;
      addr       <= '0;
      len        <= '0;
      low_byte   <= '0;
    end else begin
      code_we <= 1'b0;

      if (busy) begin
        timer <= rx_valid ? '0 : timer + TW'(1);
      end

      unique case (state)
        IDLE, RUN, FAIL: begin
          if (rx_valid && rx_data == MAGIC) begin
            state     <= LEN_LO;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            error     <= 1'b0;
            chk       <= '0;
            addr      <= '0;
            timer     <= '0;
          end
        end
        LEN_LO: begin
          if (rx_valid) begin
            len[7:0] <= rx_data;
            chk      <= chk ^ rx_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            len <= len_next;
            chk <= chk ^ rx_data;
            if (len_next == 16'd0) begin
              state <= CHECK;
            end else if (len_too_big) begin
              state     <= FAIL;
              busy      <= 1'b0;
              error     <= 1'b1;
              cpu_reset <= 1'b1;
            end else begin
              state <= DATA_LO;
            end
          end
        end
        DATA_LO: begin
          if (rx_valid) begin
            low_byte <= rx_data;
            chk      <= chk ^ rx_data;
            state    <= DATA_HI;
          end
        end
        DATA_HI: begin
          if (rx_valid) begin
            code_we    <= 1'b1;
            code_waddr <= addr[CODE_WIDTH-1:0];
            code_wdata <= {rx_data, low_byte};
            addr       <= addr_inc;
            chk        <= chk ^ rx_data;
            state      <= last_word ? CHECK : DATA_LO;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == chk) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
            end else begin
              state     <= FAIL;
              error     <= 1'b1;
              cpu_reset <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A quiet line for TIMEOUT clocks abandons the load; a byte arriving
      // in that same cycle keeps the load alive instead.
      if (busy && !rx_valid && timer == TIMER_LAST) begin
        state     <= FAIL;
        busy      <= 1'b0;
        error     <= 1'b1;
        cpu_reset <= 1'b1;
        timer     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: a table of bytes with the outputs
// expected after each one, then hand-written timeout and reset sequences.
module tb_code_loader;

  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          code_we;
  logic [CW-1:0] code_waddr;
  logic [15:0]   code_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          error;

  code_loader #(.CODE_WIDTH(CW), .MAGIC(8'hB5), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .code_we    (code_we),
    .code_waddr (code_waddr),
    .code_wdata (code_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;

  // Count write pulses (each code_we high cycle is one pulse).
  always @(posedge clk) if (code_we) we_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; the byte is taken on the next posedge and the
  // task returns at the following negedge, where outputs are sampled.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        we;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        cpu_reset;
    logic        busy;
    logic        error;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] d, input logic we, input logic [12:0] a,
                              input logic [15:0] w, input logic cr, input logic b, input logic e);
    vec_t v;
    v.data = d; v.we = we; v.addr = a; v.wdata = w;
    v.cpu_reset = cr; v.busy = b; v.error = e;
    vecs.push_back(v);
  endfunction

  // Loading bytes: no write, CPU held, busy, no error.
  function automatic void add_ld(input logic [7:0] d);
    add(d, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic void add_wr(input logic [7:0] d, input logic [12:0] a, input logic [15:0] w);
    add(d, 1'b1, a, w, 1'b1, 1'b1, 1'b0);
  endfunction

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Two-word frame: 02^00^34^12^78^56 = 0x0A.
    add_ld(8'hB5); add_ld(8'h02); add_ld(8'h00); add_ld(8'h34);
    add_wr(8'h12, 13'd0, 16'h1234); add_ld(8'h78);
    add_wr(8'h56, 13'd1, 16'h5678);
    add(8'h0A, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    add(8'h11, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);     // ignored in RUN
    // Same frame with a bad checksum: writes still happen, then FAIL.
    add_ld(8'hB5); add_ld(8'h02); add_ld(8'h00); add_ld(8'h34);
    add_wr(8'h12, 13'd0, 16'h1234); add_ld(8'h78);
    add_wr(8'h56, 13'd1, 16'h5678);
    add(8'h4F, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    add(8'h22, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);     // ignored in FAIL
    // MAGIC clears error; empty frame goes straight to RUN.
    add_ld(8'hB5); add_ld(8'h00); add_ld(8'h00);
    add(8'h00, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    // LEN = 0x2001 exceeds 8192 words: FAIL right after LEN_HI.
    add_ld(8'hB5); add_ld(8'h01);
    add(8'h20, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    // MAGIC values inside a frame are plain data: 01^00^B5^B5 = 0x01.
    add_ld(8'hB5); add_ld(8'h01); add_ld(8'h00); add_ld(8'hB5);
    add_wr(8'hB5, 13'd0, 16'hB5B5);
    add(8'h01, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_we",        32'(code_we),   32'd0);
    check("rst_waddr",     32'(code_waddr), 32'd0);
    check("rst_wdata",     32'(code_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].data);
      check($sformatf("v%0d_we", i),        32'(code_we),   32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d_waddr", i),   32'(code_waddr), 32'(vecs[i].addr));
        check($sformatf("v%0d_wdata", i),   32'(code_wdata), 32'(vecs[i].wdata));
      end
      check($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset), 32'(vecs[i].cpu_reset));
      check($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].busy));
      check($sformatf("v%0d_error", i),     32'(error),     32'(vecs[i].error));
    end
    check("table_we_pulses", 32'(we_pulses), 32'd5);

    // Timeout: 15 quiet clocks keep the load alive, the 16th fails it.
    send(8'hB5); send(8'h02); send(8'h00); send(8'h34);
    idle(15);
    check("to_busy_before", 32'(busy),  32'd1);
    check("to_err_before",  32'(error), 32'd0);
    idle(1);
    check("to_busy",      32'(busy),      32'd0);
    check("to_error",     32'(error),     32'd1);
    check("to_cpu_reset", 32'(cpu_reset), 32'd1);
    check("to_we_pulses", 32'(we_pulses), 32'd5);

    // A byte in the timeout cycle wins; the frame then completes.
    send(8'hB5); send(8'h02); send(8'h00); send(8'h34);
    idle(15);
    send(8'h12);
    check("tw_we",    32'(code_we),    32'd1);
    check("tw_wdata", 32'(code_wdata), 32'h1234);
    check("tw_busy",  32'(busy),       32'd1);
    check("tw_error", 32'(error),      32'd0);
    send(8'h78); send(8'h56); send(8'h0A);
    check("tw_cpu_reset", 32'(cpu_reset), 32'd0);
    check("tw_we_pulses", 32'(we_pulses), 32'd7);

    // LEN = 0x2000 (full memory) is accepted, then times out.
    send(8'hB5); send(8'h00); send(8'h20);
    check("full_busy",  32'(busy),  32'd1);
    check("full_error", 32'(error), 32'd0);
    idle(16);
    check("full_to_error", 32'(error), 32'd1);

    // Asynchronous reset between the low and high byte.
    send(8'hB5); send(8'h01); send(8'h00); send(8'h34);
    reset = 1'b1;
    #1;
    check("ar_cpu_reset", 32'(cpu_reset),  32'd1);
    check("ar_busy",      32'(busy),       32'd0);
    check("ar_error",     32'(error),      32'd0);
    check("ar_waddr",     32'(code_waddr), 32'd0);
    check("ar_wdata",     32'(code_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(8'h12);
    check("ar_we",        32'(code_we),   32'd0);
    check("ar_busy2",     32'(busy),      32'd0);
    check("ar_cpu_held",  32'(cpu_reset), 32'd1);
    check("ar_we_pulses", 32'(we_pulses), 32'd7);
    send(8'hB5); send(8'h00); send(8'h00); send(8'h00);
    check("ar_run_cpu_reset", 32'(cpu_reset), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
